// File: rtl/msdf_balanced_fork.sv
// Balanced fork for MSDF digit streams: every accepted digit is copied once to each
// output channel, with a private FIFO per channel and zero-latency bypass when empty.
module msdf_balanced_fork #(
  parameter int DIGIT_W    = 2,
  parameter int NUM_OUT    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int IDX_W      = 8,
  localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [DIGIT_W-1:0]         dataInArray,
  input  logic                       lastIn,
  input  logic                       pValidArray,
  output logic                       readyArray,
  output logic [NUM_OUT*DIGIT_W-1:0] dataOutArray,
  output logic [NUM_OUT-1:0]         lastOut,
  output logic [NUM_OUT-1:0]         validArray,
  input  logic [NUM_OUT-1:0]         nReadyArray,
  output logic [NUM_OUT*LW-1:0]      level,
  output logic [IDX_W-1:0]           digitIdx
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic               w_xfer;
  logic [NUM_OUT-1:0] w_ok;
  logic [IDX_W-1:0]   r_idx;

  // A full channel only blocks upstream if it is not draining this cycle.
  assign readyArray = &w_ok;
  assign w_xfer     = pValidArray & readyArray;
  assign digitIdx   = r_idx;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_ch
    logic [DIGIT_W:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]    r_rd;
    logic [PW-1:0]    r_wr;
    logic [LW-1:0]    r_cnt;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic [DIGIT_W:0] w_head;

    assign w_empty = (r_cnt == '0);
    assign w_ok[g] = (r_cnt != LW'(FIFO_DEPTH)) | nReadyArray[g];
    assign w_pop   = ~w_empty & nReadyArray[g];
    // Bypassed digits consumed in the same cycle never touch storage.
    assign w_push  = w_xfer & ~(w_empty & nReadyArray[g]);
    assign w_head  = r_mem[r_rd];

    assign dataOutArray[g*DIGIT_W +: DIGIT_W] = w_empty ? dataInArray : w_head[DIGIT_W-1:0];
    assign lastOut[g]         = w_empty ? lastIn : w_head[DIGIT_W];
    assign validArray[g]      = w_empty ? w_xfer : 1'b1;
    assign level[g*LW +: LW]  = r_cnt;

    always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= {lastIn, dataInArray};
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_rd  <= '0;
        r_wr  <= '0;
        r_cnt <= '0;
      end else begin
        if (w_push) r_wr <= (r_wr == PW'(FIFO_DEPTH - 1)) ? '0 : r_wr + PW'(1);
        if (w_pop)  r_rd <= (r_rd == PW'(FIFO_DEPTH - 1)) ? '0 : r_rd + PW'(1);
        case ({w_push, w_pop})
          2'b10:   r_cnt <= r_cnt + LW'(1);
          2'b01:   r_cnt <= r_cnt - LW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      if (lastIn)           r_idx <= '0;
      else if (r_idx != '1) r_idx <= r_idx + IDX_W'(1);
    end
  end

endmodule

// File: tb/tb_msdf_balanced_fork.sv
// Scoreboard bench for msdf_balanced_fork: two instances (depth 16 / idx 8 and
// depth 5 / idx 3) checked against per-channel queue models of outstanding digits.
module tb_msdf_balanced_fork;

  logic       clk = 1'b0;
  logic       rstn;
  logic       pv   [2];
  logic       lin  [2];
  logic [1:0] din  [2];
  logic [3:0] nr   [2];
  logic       rdy  [2];
  logic [7:0] dout [2];
  logic [3:0] lout [2];
  logic [3:0] vout [2];
  logic [19:0] levA;
  logic [11:0] levB;
  logic [7:0]  idxA;
  logic [2:0]  idxB;

  int npass = 0;
  int nchk  = 0;

  // Outstanding (delivered-later) entries {last,digit} per dut*4+channel.
  logic [2:0] q [8][$];
  int         midx [2];

  always #5 clk = ~clk;

  msdf_balanced_fork #(.DIGIT_W(2), .NUM_OUT(4), .FIFO_DEPTH(16), .IDX_W(8)) u_a (
    .clk(clk), .rstn(rstn), .dataInArray(din[0]), .lastIn(lin[0]), .pValidArray(pv[0]),
    .readyArray(rdy[0]), .dataOutArray(dout[0]), .lastOut(lout[0]), .validArray(vout[0]),
    .nReadyArray(nr[0]), .level(levA), .digitIdx(idxA));

  msdf_balanced_fork #(.DIGIT_W(2), .NUM_OUT(4), .FIFO_DEPTH(5), .IDX_W(3)) u_b (
    .clk(clk), .rstn(rstn), .dataInArray(din[1]), .lastIn(lin[1]), .pValidArray(pv[1]),
    .readyArray(rdy[1]), .dataOutArray(dout[1]), .lastOut(lout[1]), .validArray(vout[1]),
    .nReadyArray(nr[1]), .level(levB), .digitIdx(idxB));

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
  endtask

  function automatic int get_lvl(input int d, input int ch);
    return (d == 0) ? int'(levA[ch*5 +: 5]) : int'(levB[ch*3 +: 3]);
  endfunction

  function automatic int get_idx(input int d);
    return (d == 0) ? int'(idxA) : int'(idxB);
  endfunction

  // Monitor / reference model, evaluated mid-cycle once inputs have settled.
  always @(negedge clk) begin
    int         depth, maxi, n, k;
    bit         mready, xfer, ev;
    logic [2:0] inent, exp;
    for (int d = 0; d < 2; d++) begin
      depth = (d == 0) ? 16 : 5;
      maxi  = (d == 0) ? 255 : 7;
      if (!rstn) begin
        chk("rst_valid", int'(vout[d]), pv[d] ? 15 : 0);
        chk("rst_ready", int'(rdy[d]), 1);
        for (int ch = 0; ch < 4; ch++) begin
          chk("rst_level", get_lvl(d, ch), 0);
          q[d*4+ch].delete();
        end
        midx[d] = 0;
      end else begin
        mready = 1'b1;
        for (int ch = 0; ch < 4; ch++) begin
          n = q[d*4+ch].size();
          if (!(n < depth || (nr[d][ch] && n > 0))) mready = 1'b0;
        end
        chk("ready", int'(rdy[d]), int'(mready));
        chk("digitIdx", get_idx(d), midx[d]);
        xfer  = pv[d] && mready;
        inent = {lin[d], din[d]};
        for (int ch = 0; ch < 4; ch++) begin
          k  = d*4 + ch;
          n  = q[k].size();
          ev = (n > 0) || xfer;
          chk("level", get_lvl(d, ch), n);
          chk("valid", int'(vout[d][ch]), int'(ev));
          if (ev) begin
            exp = (n > 0) ? q[k][0] : inent;
            chk("data", int'(dout[d][ch*2 +: 2]), int'(exp[1:0]));
            chk("last", int'(lout[d][ch]), int'(exp[2]));
          end
          if (n > 0 && nr[d][ch]) void'(q[k].pop_front());
          if (xfer && !(n == 0 && nr[d][ch])) q[k].push_back(inent);
        end
        if (xfer) begin
          if (lin[d])              midx[d] = 0;
          else if (midx[d] < maxi) midx[d] = midx[d] + 1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input int cycles);
    pv[d]  = 1'b0;
    lin[d] = 1'b0;
    nr[d]  = 4'hF;
    repeat (cycles) step();
  endtask

  initial begin
    int  k, iters;
    bit  fire;
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pv[d] = 1'b0; lin[d] = 1'b0; din[d] = 2'b00; nr[d] = 4'hF;
    end
    repeat (3) step();
    pv[0] = 1'b1;
    step();
    pv[0] = 1'b0;
    rstn  = 1'b1;
    step();

    // All channels ready: 8-digit frame bypasses to every channel at once.
    for (int i = 0; i < 8; i++) begin
      pv[0] = 1'b1; din[0] = 2'($urandom); lin[0] = (i == 7);
      step();
    end
    idle(0, 2);

    // Channel 2 stalls for 5 transfers, then drains.
    nr[0] = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      pv[0] = 1'b1; din[0] = 2'($urandom); lin[0] = 1'b0;
      step();
    end
    chk("skew_level2", get_lvl(0, 2), 5);
    idle(0, 8);

    // Channel 1 stalls for 20 valid cycles, filling its FIFO.
    nr[0] = 4'b1101;
    for (int i = 0; i < 20; i++) begin
      pv[0] = 1'b1; din[0] = 2'($urandom); lin[0] = 1'b0;
      step();
    end
    @(negedge clk);
    chk("full_ready_low", int'(rdy[0]), 0);
    chk("full_level1", get_lvl(0, 1), 16);
    nr[0] = 4'hF;
    #1;
    chk("full_ready_pop", int'(rdy[0]), 1);
    step();
    chk("full_level_hold", get_lvl(0, 1), 16);
    lin[0] = 1'b1;
    step();
    idle(0, 20);

    // Build up level[3]=7 then reset mid-frame.
    nr[0] = 4'b0111;
    for (int i = 0; i < 7; i++) begin
      pv[0] = 1'b1; din[0] = 2'($urandom); lin[0] = 1'b0;
      step();
    end
    pv[0] = 1'b0;
    chk("pre_reset_level3", get_lvl(0, 3), 7);
    rstn = 1'b0;
    #1;
    chk("reset_level3", get_lvl(0, 3), 0);
    for (int i = 0; i < 4; i++) begin
      pv[0] = i[0];
      step();
    end
    pv[0] = 1'b0; nr[0] = 4'hF;
    rstn = 1'b1;
    step();
    chk("post_reset_idx", get_idx(0), 0);
    for (int i = 0; i < 4; i++) begin
      pv[0] = 1'b1; din[0] = 2'($urandom); lin[0] = (i == 3);
      step();
    end
    idle(0, 2);

    // Depth-5 instance: 200 digits with random per-channel ready, last every 10th.
    k = 0; iters = 0;
    while (k < 200 && iters < 4000) begin
      pv[1]  = ($urandom_range(0, 9) < 8);
      din[1] = 2'($urandom);
      lin[1] = ((k % 10) == 9);
      nr[1]  = 4'($urandom);
      @(negedge clk);
      fire = pv[1] && rdy[1];
      step();
      if (fire) k++;
      iters++;
    end
    if (k < 200) chk("wrap_timeout", k, 200);
    idle(1, 10);

    // Index saturation on the 3-bit counter.
    for (int i = 0; i < 12; i++) begin
      pv[1] = 1'b1; din[1] = 2'($urandom); lin[1] = 1'b0;
      step();
    end
    pv[1] = 1'b0;
    chk("idx_saturate", get_idx(1), 7);
    pv[1] = 1'b1; lin[1] = 1'b1;
    step();
    pv[1] = 1'b0; lin[1] = 1'b0;
    chk("idx_return", get_idx(1), 0);
    idle(1, 3);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
